// File: rtl/rat_ctrl_pkg.sv
// Shared definitions for the RAT CPU control path.
// Used by the opcode decoder and by the pipeline sequencer (rat_pipe_ctrl).
// Contents: the sequencer state encoding, the PC source select codes, the
// conditional-branch type codes and the scratch-RAM address select for SP-1.
package rat_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_ENTER  = 2'd1,
    ST_BUBBLE = 2'd2
  } ctrl_state_t;

  // PC_MUX_SEL sources
  localparam logic [1:0] PCSEL_IMM   = 2'b00;
  localparam logic [1:0] PCSEL_STACK = 2'b01;
  localparam logic [1:0] PCSEL_VEC   = 2'b10;
  localparam logic [1:0] PCSEL_FDPC  = 2'b11;

  // Conditional branch types
  localparam logic [1:0] BRN_BRCC = 2'b00;
  localparam logic [1:0] BRN_BRCS = 2'b01;
  localparam logic [1:0] BRN_BREQ = 2'b10;
  localparam logic [1:0] BRN_BRNE = 2'b11;

  // Scratch RAM address select: stack pointer minus one
  localparam logic [1:0] SCRADDR_SP_M1 = 2'b11;

endpackage

// File: rtl/rat_pipe_ctrl_if.sv
// Handshake bundle between the decoder/datapath side and the pipeline
// sequencer.
//   master : decoder/datapath side; drives flags, interrupt request, EX
//            validity and redirect requests; receives PC/FD/interrupt
//            controls.
//   slave  : rat_pipe_ctrl.
interface rat_pipe_ctrl_if;
  // requests and status into the sequencer
  logic       int_req;
  logic       i_flag;
  logic       c_flag;
  logic       z_flag;
  logic       ex_valid;
  logic       cu_pc_ld;
  logic [1:0] cu_pc_mux_sel;
  logic       cu_cond_brn;
  logic [1:0] cu_cond_brn_type;
  // controls out of the sequencer
  logic       pc_ld;
  logic [1:0] pc_mux_sel;
  logic       fd_stall;
  logic       fd_flush;
  logic       ex_kill;
  logic       int_active;
  logic       int_sp_decr;
  logic       int_scr_we;
  logic       int_scr_data_sel;
  logic [1:0] int_scr_addr_sel;
  logic       int_flg_shad_ld;
  logic       int_i_clr;
  logic       int_ack;
  logic       brn_taken;

  modport master (
    output int_req, i_flag, c_flag, z_flag, ex_valid,
           cu_pc_ld, cu_pc_mux_sel, cu_cond_brn, cu_cond_brn_type,
    input  pc_ld, pc_mux_sel, fd_stall, fd_flush, ex_kill, int_active,
           int_sp_decr, int_scr_we, int_scr_data_sel, int_scr_addr_sel,
           int_flg_shad_ld, int_i_clr, int_ack, brn_taken
  );

  modport slave (
    input  int_req, i_flag, c_flag, z_flag, ex_valid,
           cu_pc_ld, cu_pc_mux_sel, cu_cond_brn, cu_cond_brn_type,
    output pc_ld, pc_mux_sel, fd_stall, fd_flush, ex_kill, int_active,
           int_sp_decr, int_scr_we, int_scr_data_sel, int_scr_addr_sel,
           int_flg_shad_ld, int_i_clr, int_ack, brn_taken
  );

endinterface

// File: rtl/rat_branch_eval.sv
// Conditional branch resolution for the instruction in EX.
// Ports:
//   ex_valid  in  EX holds a real instruction
//   cond_brn  in  decoder requests a conditional branch
//   brn_type  in  BRCC / BRCS / BREQ / BRNE
//   c_flag    in  carry flag
//   z_flag    in  zero flag
//   taken     out branch is taken this cycle (purely combinational)
module rat_branch_eval (
  input  logic       ex_valid,
  input  logic       cond_brn,
  input  logic [1:0] brn_type,
  input  logic       c_flag,
  input  logic       z_flag,
  output logic       taken
);
  import rat_ctrl_pkg::*;

  logic cond;

  always_comb begin
    cond = 1'b0;
    case (brn_type)
      BRN_BRCC: cond = ~c_flag;
      BRN_BRCS: cond =  c_flag;
      BRN_BREQ: cond =  z_flag;
      BRN_BRNE: cond = ~z_flag;
      default:  cond = 1'b0;
    endcase
  end

  assign taken = ex_valid & cond_brn & cond;

endmodule

// File: rtl/rat_pipe_ctrl.sv
// Pipeline sequencer for the RAT CPU: resolves conditional branches,
// redirects the PC, flushes/stalls the FD register and runs interrupt entry.
// Ports:
//   clk  in   system clock, rising edge
//   rst  in   synchronous active-high reset; forces every output low
//   bus  slave side of rat_pipe_ctrl_if (requests in, PC/FD/interrupt
//        controls out)
// Parameter FLUSH_CYCLES (1..3): FD bubble cycles after a redirect,
// counting the redirect cycle itself.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_RUN    | normal flow; redirects and interrupt accept decoded from inputs
// ST_ENTER  | interrupt entry: vector PC, push return address, clear I
// ST_BUBBLE | extra FD bubble cycles; cnt counts down to 1 then back to RUN
module rat_pipe_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input logic           clk,
  input logic           rst,
  rat_pipe_ctrl_if.slave bus
);
  import rat_ctrl_pkg::*;

  localparam logic [1:0] CNT_INIT = 2'(FLUSH_CYCLES - 1);
  localparam bit         MULTI    = (FLUSH_CYCLES > 1);

  ctrl_state_t state, state_nx;
  logic [1:0]  cnt, cnt_nx;
  logic        int_pend, int_pend_nx;
  logic        taken;
  logic        redirect;
  logic        accept;

  rat_branch_eval u_brn (
    .ex_valid (bus.ex_valid),
    .cond_brn (bus.cu_cond_brn),
    .brn_type (bus.cu_cond_brn_type),
    .c_flag   (bus.c_flag),
    .z_flag   (bus.z_flag),
    .taken    (taken)
  );

  assign redirect = bus.ex_valid & (bus.cu_pc_ld | taken);
  assign accept   = int_pend & bus.i_flag;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_RUN;
      cnt      <= 2'd0;
      int_pend <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      int_pend <= int_pend_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    int_pend_nx = int_pend | bus.int_req;
    case (state)
      ST_RUN: begin
        // redirect wins; a pending interrupt waits for a redirect-free cycle
        if (redirect) begin
          if (MULTI) begin
            state_nx = ST_BUBBLE;
            cnt_nx   = CNT_INIT;
          end
        end else if (accept) begin
          state_nx = ST_ENTER;
        end
      end
      ST_ENTER: begin
        // clearing wins over a request seen in the entry cycle itself
        int_pend_nx = 1'b0;
        if (MULTI) begin
          state_nx = ST_BUBBLE;
          cnt_nx   = CNT_INIT;
        end else begin
          state_nx = ST_RUN;
        end
      end
      ST_BUBBLE: begin
        cnt_nx = cnt - 2'd1;
        if (cnt == 2'd1) state_nx = ST_RUN;
      end
      default: begin
        state_nx = ST_RUN;
        cnt_nx   = 2'd0;
      end
    endcase
  end

  always_comb begin
    bus.pc_ld            = 1'b0;
    bus.pc_mux_sel       = PCSEL_IMM;
    bus.fd_stall         = 1'b0;
    bus.fd_flush         = 1'b0;
    bus.ex_kill          = 1'b0;
    bus.int_active       = 1'b0;
    bus.int_sp_decr      = 1'b0;
    bus.int_scr_we       = 1'b0;
    bus.int_scr_data_sel = 1'b0;
    bus.int_scr_addr_sel = 2'b00;
    bus.int_flg_shad_ld  = 1'b0;
    bus.int_i_clr        = 1'b0;
    bus.int_ack          = 1'b0;
    bus.brn_taken        = 1'b0;
    // gating with rst keeps a reset landing in ENTER from committing a push
    if (!rst) begin
      case (state)
        ST_RUN: begin
          if (redirect) begin
            bus.pc_ld      = 1'b1;
            bus.pc_mux_sel = taken ? PCSEL_IMM : bus.cu_pc_mux_sel;
            bus.brn_taken  = taken;
            bus.fd_flush   = 1'b1;
          end else if (accept) begin
            // rewind to the instruction sitting in FD so it reruns after RETI
            bus.pc_ld      = 1'b1;
            bus.pc_mux_sel = PCSEL_FDPC;
            bus.fd_flush   = 1'b1;
          end
        end
        ST_ENTER: begin
          bus.pc_ld            = 1'b1;
          bus.pc_mux_sel       = PCSEL_VEC;
          bus.fd_flush         = 1'b1;
          bus.ex_kill          = 1'b1;
          bus.int_active       = 1'b1;
          bus.int_sp_decr      = 1'b1;
          bus.int_scr_we       = 1'b1;
          bus.int_scr_data_sel = 1'b1;
          bus.int_scr_addr_sel = SCRADDR_SP_M1;
          bus.int_flg_shad_ld  = 1'b1;
          bus.int_i_clr        = 1'b1;
          bus.int_ack          = 1'b1;
        end
        ST_BUBBLE: begin
          bus.fd_stall = 1'b1;
          bus.fd_flush = 1'b1;
          bus.ex_kill  = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rat_pipe_ctrl.sv
// Bench for rat_pipe_ctrl. Two instances: FLUSH_CYCLES=1 (d1) and
// FLUSH_CYCLES=3 (d3). Each cycle the expected output word is queued as the
// inputs are driven and popped/compared at the following falling edge.
// Output word layout (MSB first): pc_ld, pc_mux_sel[1:0], fd_stall, fd_flush,
// ex_kill, int_active, int_sp_decr, int_scr_we, int_scr_data_sel,
// int_flg_shad_ld, int_i_clr, int_scr_addr_sel[1:0], int_ack, brn_taken.
module tb_rat_pipe_ctrl;

  logic clk;
  logic rst;

  rat_pipe_ctrl_if if1 ();
  rat_pipe_ctrl_if if3 ();

  rat_pipe_ctrl #(.FLUSH_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  rat_pipe_ctrl #(.FLUSH_CYCLES(3)) dut3 (.clk(clk), .rst(rst), .bus(if3));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [15:0] obs1, obs3;
  assign obs1 = {if1.pc_ld, if1.pc_mux_sel, if1.fd_stall, if1.fd_flush,
                 if1.ex_kill, if1.int_active, if1.int_sp_decr, if1.int_scr_we,
                 if1.int_scr_data_sel, if1.int_flg_shad_ld, if1.int_i_clr,
                 if1.int_scr_addr_sel, if1.int_ack, if1.brn_taken};
  assign obs3 = {if3.pc_ld, if3.pc_mux_sel, if3.fd_stall, if3.fd_flush,
                 if3.ex_kill, if3.int_active, if3.int_sp_decr, if3.int_scr_we,
                 if3.int_scr_data_sel, if3.int_flg_shad_ld, if3.int_i_clr,
                 if3.int_scr_addr_sel, if3.int_ack, if3.brn_taken};

  typedef struct {
    string       tag;
    int          dut;   // 0 both, 1 d1, 3 d3
    logic [15:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic logic [15:0] pack_out(
    input logic pc_ld, input logic [1:0] sel, input logic stall,
    input logic flush, input logic kill, input logic act, input logic spd,
    input logic we, input logic dsel, input logic shad, input logic iclr,
    input logic [1:0] asel, input logic ack, input logic tk);
    return {pc_ld, sel, stall, flush, kill, act, spd, we, dsel, shad, iclr,
            asel, ack, tk};
  endfunction

  function automatic logic [15:0] redir(input logic [1:0] sel, input logic tk);
    return pack_out(1'b1, sel, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                    1'b0, 1'b0, 2'b00, 1'b0, tk);
  endfunction

  logic [15:0] e_zero, e_rew, e_enter, e_bub;

  task automatic chk_eq(input string tag, input logic [15:0] obs,
                        input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_if1(input logic irq, input logic ifl, input logic cf,
                         input logic zf, input logic exv, input logic cb,
                         input logic [1:0] bt, input logic pcld,
                         input logic [1:0] psel);
    if1.int_req = irq;  if1.i_flag = ifl;  if1.c_flag = cf;  if1.z_flag = zf;
    if1.ex_valid = exv; if1.cu_cond_brn = cb; if1.cu_cond_brn_type = bt;
    if1.cu_pc_ld = pcld; if1.cu_pc_mux_sel = psel;
  endtask

  task automatic set_if3(input logic irq, input logic ifl, input logic cf,
                         input logic zf, input logic exv, input logic cb,
                         input logic [1:0] bt, input logic pcld,
                         input logic [1:0] psel);
    if3.int_req = irq;  if3.i_flag = ifl;  if3.c_flag = cf;  if3.z_flag = zf;
    if3.ex_valid = exv; if3.cu_cond_brn = cb; if3.cu_cond_brn_type = bt;
    if3.cu_pc_ld = pcld; if3.cu_pc_mux_sel = psel;
  endtask

  // drive one DUT (the other gets idle zeros); dut 0 drives both
  task automatic drive(input int dut, input logic irq, input logic ifl,
                       input logic cf, input logic zf, input logic exv,
                       input logic cb, input logic [1:0] bt,
                       input logic pcld, input logic [1:0] psel);
    set_if1(0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00);
    set_if3(0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00);
    if (dut != 3) set_if1(irq, ifl, cf, zf, exv, cb, bt, pcld, psel);
    if (dut != 1) set_if3(irq, ifl, cf, zf, exv, cb, bt, pcld, psel);
  endtask

  // queue the expectation for the current inputs, compare at the falling edge
  task automatic cyc(input string tag, input int dut, input logic [15:0] e);
    exp_t x;
    x.tag = tag; x.dut = dut; x.exp = e;
    sb_q.push_back(x);
    @(negedge clk);
    while (sb_q.size() > 0) begin
      x = sb_q.pop_front();
      if (x.dut != 3) chk_eq({x.tag, "/d1"}, obs1, x.exp);
      if (x.dut != 1) chk_eq({x.tag, "/d3"}, obs3, x.exp);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    e_zero  = 16'h0000;
    e_rew   = pack_out(1, 2'b11, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
    e_enter = pack_out(1, 2'b10, 0, 1, 1, 1, 1, 1, 1, 1, 1, 2'b11, 1, 0);
    e_bub   = pack_out(0, 2'b00, 1, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0);

    // reset with INT and an unconditional redirect pending
    rst = 1'b1;
    drive(0, 1, 1, 0, 0, 1, 0, 2'b00, 1, 2'b01);
    cyc("rst0", 0, e_zero);
    cyc("rst1", 0, e_zero);
    rst = 1'b0;
    drive(0, 0, 1, 0, 0, 0, 0, 2'b00, 0, 2'b00);
    cyc("post_rst0", 0, e_zero);
    cyc("post_rst1", 0, e_zero);
    cyc("post_rst2", 0, e_zero);

    // branch resolution on d1 (irq, ifl, c, z, exv, cb, type, pcld, psel)
    drive(1, 0, 1, 0, 1, 1, 1, 2'b10, 0, 2'b00);
    cyc("breq_z1", 1, redir(2'b00, 1));
    drive(1, 0, 1, 0, 0, 1, 1, 2'b10, 0, 2'b00);
    cyc("breq_z0", 1, e_zero);
    drive(1, 0, 1, 0, 1, 0, 1, 2'b10, 0, 2'b00);
    cyc("breq_exv0", 1, e_zero);
    drive(1, 0, 1, 1, 0, 1, 1, 2'b00, 0, 2'b00);
    cyc("brcc_c1", 1, e_zero);
    drive(1, 0, 1, 1, 0, 1, 1, 2'b01, 0, 2'b00);
    cyc("brcs_c1", 1, redir(2'b00, 1));
    drive(1, 0, 1, 0, 0, 1, 1, 2'b11, 0, 2'b00);
    cyc("brne_z0", 1, redir(2'b00, 1));
    drive(1, 0, 1, 0, 0, 1, 0, 2'b00, 1, 2'b01);
    cyc("ret_ld", 1, redir(2'b01, 0));
    drive(1, 0, 1, 0, 0, 0, 0, 2'b00, 1, 2'b10);
    cyc("ret_exv0", 1, e_zero);

    // single interrupt pulse, I=1, no redirect
    drive(1, 1, 1, 0, 0, 0, 0, 2'b00, 0, 2'b00);
    cyc("int_edge", 1, e_zero);
    drive(1, 0, 1, 0, 0, 0, 0, 2'b00, 0, 2'b00);
    cyc("int_rewind", 1, e_rew);
    cyc("int_enter", 1, e_enter);
    cyc("int_done0", 1, e_zero);
    cyc("int_done1", 1, e_zero);

    // reset landing in ENTER: nothing committed, pending cleared
    drive(1, 1, 1, 0, 0, 0, 0, 2'b00, 0, 2'b00);
    cyc("mr_edge", 1, e_zero);
    drive(1, 0, 1, 0, 0, 0, 0, 2'b00, 0, 2'b00);
    cyc("mr_rewind", 1, e_rew);
    rst = 1'b1;
    cyc("mr_enter_rst", 0, e_zero);
    rst = 1'b0;
    cyc("mr_after0", 0, e_zero);
    cyc("mr_after1", 0, e_zero);

    // pending interrupt coincides with a taken branch; ENTER ignores redirect
    drive(1, 1, 1, 0, 0, 0, 0, 2'b00, 0, 2'b00);
    cyc("co_edge", 1, e_zero);
    drive(1, 0, 1, 0, 1, 1, 1, 2'b10, 0, 2'b00);
    cyc("co_brn", 1, redir(2'b00, 1));
    drive(1, 0, 1, 0, 0, 0, 0, 2'b00, 0, 2'b00);
    cyc("co_rewind", 1, e_rew);
    drive(1, 0, 1, 0, 1, 1, 1, 2'b10, 0, 2'b00);
    cyc("co_enter", 1, e_enter);
    drive(1, 0, 1, 0, 0, 0, 0, 2'b00, 0, 2'b00);
    cyc("co_done", 1, e_zero);

    // FLUSH_CYCLES=3: taken branch, bubbles ignore the held redirect
    drive(3, 0, 1, 0, 1, 1, 1, 2'b10, 0, 2'b00);
    cyc("f3_brn", 3, redir(2'b00, 1));
    cyc("f3_bub1", 3, e_bub);
    cyc("f3_bub2", 3, e_bub);
    drive(3, 0, 1, 0, 0, 0, 0, 2'b00, 0, 2'b00);
    cyc("f3_run", 3, e_zero);

    // interrupt held off by I=0, then accepted
    drive(3, 1, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00);
    cyc("f3_int_edge", 3, e_zero);
    drive(3, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00);
    for (int i = 0; i < 3; i++) cyc($sformatf("f3_i0_%0d", i), 3, e_zero);
    drive(3, 0, 1, 0, 0, 0, 0, 2'b00, 0, 2'b00);
    cyc("f3_accept", 3, e_rew);
    cyc("f3_enter", 3, e_enter);
    cyc("f3_ebub1", 3, e_bub);
    cyc("f3_ebub2", 3, e_bub);
    cyc("f3_erun", 3, e_zero);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rat_pipe_ctrl.md
# rat_pipe_ctrl

Pipeline sequencer for the RAT CPU. It sits between the combinational opcode decoder and the PC / fetch-decode (FD) register. It resolves the decoder's conditional-branch requests against the C/Z flags and redirects the PC. It also flushes and stalls the FD register, and it runs the multi-cycle interrupt entry: rewind the PC, push the return address, vector, clear I, and shadow the flags.

## Interface
- FLUSH_CYCLES, 1: FD bubble cycles after any PC redirect, including the redirect cycle. Legal range 1..3.
- CLK  in  1  system clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- INT  in  1  external interrupt request, level, already synchronous to CLK.
- I_FLAG, C_FLAG, Z_FLAG  in  1 each  current interrupt-enable, carry and zero flags.
- EX_VALID  in  1  EX stage holds a real (non-bubble) instruction.
- CU_PC_LD  in  1, CU_PC_MUX_SEL  in  2  unconditional redirect from the decoder (BRN/CALL/RET/RETI*).
- CU_COND_BRN  in  1, CU_COND_BRN_TYPE  in  2  conditional branch request. Types: 00 BRCC, 01 BRCS, 10 BREQ, 11 BRNE.
- PC_LD  out  1, PC_MUX_SEL  out  2  PC load and source. Sources: 00 immediate, 01 stack, 10 vector, 11 FD_PC (address held in FD).
- FD_STALL  out  1  hold PC and FD register.
- FD_FLUSH  out  1  load a bubble into the FD register.
- EX_KILL  out  1  squash EX-stage write enables.
- INT_ACTIVE  out  1  top-level selects the INT_* signals over the decoder's SP/SCR/flag signals.
- INT_SP_DECR, INT_SCR_WE, INT_SCR_DATA_SEL, INT_FLG_SHAD_LD, INT_I_CLR  out  1 each; INT_SCR_ADDR_SEL  out  2.
- INT_ACK  out  1  one-cycle pulse in the interrupt entry cycle.
- BRN_TAKEN  out  1  a conditional branch is taken this cycle.

## Operation
- taken = EX_VALID & CU_COND_BRN & cond, where cond is: BRCC ~C, BRCS C, BREQ Z, BRNE ~Z.
- redirect = EX_VALID & (CU_PC_LD | taken).
- int_pend register:
  - Set in any cycle with INT=1.
  - Cleared in ENTER and by RST.
  - Accepted only when int_pend & I_FLAG.
- States: RUN, ENTER, BUBBLE. Bubble counter cnt is 2 bits.
- RUN, priority redirect > interrupt:
  - Redirect: PC_LD=1; PC_MUX_SEL=00 if taken, else CU_PC_MUX_SEL; BRN_TAKEN=taken; FD_FLUSH=1.
    - If FLUSH_CYCLES>1: go to BUBBLE with cnt=FLUSH_CYCLES-1.
    - Otherwise stay in RUN.
  - Else, interrupt accepted: PC_LD=1, PC_MUX_SEL=11 (rewind PC to the instruction in FD), FD_FLUSH=1. Go to ENTER.
  - Else: all outputs 0.
- ENTER:
  - Assert PC_LD=1, PC_MUX_SEL=10, FD_FLUSH=1, EX_KILL=1, INT_ACTIVE=1.
  - Assert INT_SP_DECR=1, INT_SCR_WE=1, INT_SCR_DATA_SEL=1 (push PC), INT_SCR_ADDR_SEL=11 (SP-1).
  - Assert INT_FLG_SHAD_LD=1, INT_I_CLR=1, INT_ACK=1.
  - Clear int_pend.
  - Next state: BUBBLE with cnt=FLUSH_CYCLES-1 if FLUSH_CYCLES>1, else RUN.
  - Redirect inputs are ignored.
- BUBBLE:
  - Assert FD_STALL=1, FD_FLUSH=1, EX_KILL=1; cnt decrements.
  - At cnt=1, return to RUN.
  - Redirect and interrupt inputs are ignored.
- A pending interrupt that coincides with a redirect waits; it is taken on the first RUN cycle with no redirect.
- An interrupt held while I_FLAG=0 stays pending indefinitely.
- RST:
  - Next state RUN, cnt=0, int_pend=0.
  - Every output is forced to 0 while RST=1, regardless of state or inputs.
  - Mid-entry reset (RST in ENTER): no push or vector is committed in that cycle.

## Timing
- RUN outputs are combinational from the inputs: zero-cycle branch resolution, and the PC loads on the same edge.
- ENTER and BUBBLE outputs decode from registered state only.
- Interrupt latency from INT rising to INT_ACK: 2 cycles minimum (the int_pend edge, then the accept cycle). Add FLUSH_CYCLES per intervening redirect.
- After an entry, the vector instruction reaches EX FLUSH_CYCLES+1 cycles after ENTER.

## Structure
- Shared package rat_ctrl_pkg holds:
  - the state enum;
  - the PC_MUX_SEL constants (PCSEL_IMM, PCSEL_STACK, PCSEL_VEC, PCSEL_FDPC);
  - the branch-type codes;
  - SCRADDR_SP_M1 = 2'b11.
  The decoder imports the same package.
- One sub-module, rat_branch_eval: combinational cond/taken from type, C, Z and EX_VALID.

## Test plan
- Reset: RST=1 for 2 cycles with INT=1 and CU_PC_LD=1 -> all outputs 0. After RST drops with INT=0 -> no INT_ACK.
- BREQ, EX_VALID=1, Z=1 -> same cycle PC_LD=1, PC_MUX_SEL=00, BRN_TAKEN=1, FD_FLUSH=1. With Z=0 -> all 0. With EX_VALID=0 -> all 0.
- BRCC with C=1 -> not taken. BRNE with Z=0 -> taken. CU_PC_LD=1 with CU_PC_MUX_SEL=01 (RET) -> PC_MUX_SEL=01, BRN_TAKEN=0.
- INT pulse, I_FLAG=1, no redirect:
  - cycle n: PC_LD=1, PC_MUX_SEL=11, FD_FLUSH=1;
  - cycle n+1: ENTER signals exactly as specified, INT_ACK=1;
  - cycle n+2: RUN, outputs 0.
- int_pend set in the same cycle as a taken BRN, FLUSH_CYCLES=1 -> redirect first; PC_MUX_SEL=11 on the next cycle; INT_ACK one cycle later.
- FLUSH_CYCLES=3, taken branch -> FD_FLUSH high for 3 cycles, FD_STALL high on cycles 2-3, then RUN. INT with I_FLAG=0 -> no ACK until I_FLAG=1, then ACK 1 cycle after acceptance.
